inst_fetch_resp: RTL and testbench

Instruction-fetch responder: serves the fetch request (ce, pc) issued by the PC stage and returns the instruction word. It holds one LINE_WORDS-word line buffer. Each miss is burst-filled from the external instruction memory over a req/ack bus. It raises stallreq while the requested word is unavailable, so the stall controller freezes the PC stage (stall[0]).

---
 rtl/inst_fetch_resp_pkg.sv | 18 +
 rtl/inst_fetch_resp_line_buf.sv | 52 +++++
 rtl/inst_fetch_resp.sv | 133 +++++++++++++
 tb/tb_inst_fetch_resp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder.
//   - default line size
//   - fill FSM state encoding
//   - common constants: ZeroWord, Enable, Valid, Invalid
package inst_fetch_resp_pkg;

    localparam int          LINE_WORDS_DEF = 4;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        Enable         = 1'b1;
    localparam logic        Valid          = 1'b1;
    localparam logic        Invalid        = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/inst_fetch_resp_line_buf.sv
// Line buffer for the fetch responder.
// It holds LINE_WORDS data words and one valid bit per word.
// Ports:
//   clk, rst     clock; asynchronous active-low reset (clears the valid bits)
//   clear        invalidate every word (takes effect at the start of a new fill)
//   we           write enable
//   widx, wdata  write index and write data; the written word becomes valid
//   ridx         read index
//   rdata        combinational read data
//   rvalid       combinational valid bit of the word at ridx
module inst_fetch_resp_line_buf
    import inst_fetch_resp_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    output logic             rvalid
);

    logic [31:0]           words_q [LINE_WORDS];
    logic [LINE_WORDS-1:0] vld_q;

    // The data words have no reset. A word is only read once its valid bit
    // is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (we) begin
            words_q[widx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (clear) begin
            vld_q <= '0;
        end else if (we) begin
            vld_q[widx] <= Valid;
        end
    end

    assign rdata  = words_q[ridx];
    assign rvalid = vld_q[ridx];

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder.
// It serves (ce, pc) fetch requests from a single line buffer. On a miss it
// burst-fills the whole line from external memory, word 0 first, over a
// req/ack bus. While the requested word is not yet valid it asserts
// stallreq, so the PC stage holds.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ce, pc              fetch enable and fetch address (pc[1:0] ignored)
//   inst, stallreq      combinational fetch result and stall request
//   mem_req, mem_addr   registered memory read request and word address
//   mem_ack, mem_rdata  one-cycle acknowledge and the read data for it
//
// state   | meaning
// ST_IDLE | no fill in flight; a miss with ce=1 starts a fill
// ST_FILL | burst in flight; hits on words already landed are still served
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        stallreq,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int               TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(LINE_WORDS - 1);

    fill_state_e       state_q, state_d;
    logic [TAG_W-1:0]  line_tag_q, line_tag_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic              rd_valid;
    logic              hit;
    logic              buf_clear;
    logic              buf_we;
    logic              unused_pc_lsb;

    assign tag           = pc[31:IDX_W+2];
    assign idx           = pc[IDX_W+1:2];
    assign unused_pc_lsb = ^pc[1:0];

    inst_fetch_resp_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_line_buf (
        .clk    (clk),
        .rst    (rst),
        .clear  (buf_clear),
        .we     (buf_we),
        .widx   (cnt_q),
        .wdata  (mem_rdata),
        .ridx   (idx),
        .rdata  (rd_word),
        .rvalid (rd_valid)
    );

    // Hits are honoured in either state, so a fetch can restart on a word
    // as soon as its beat has landed.
    assign hit      = ce & (tag == line_tag_q) & rd_valid;
    assign inst     = hit ? rd_word : ZeroWord;
    assign stallreq = ce & ~hit;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            line_tag_q <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            line_tag_q <= line_tag_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_tag_d = line_tag_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        buf_clear  = 1'b0;
        buf_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ce && !hit) begin
                    line_tag_d = tag;
                    buf_clear  = Enable;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag, {IDX_W{1'b0}}, 2'b00};
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                // The fill is never aborted by a pc change. A miss on another
                // line simply waits for this fill to complete.
                if (mem_ack) begin
                    buf_we = Enable;
                    if (cnt_q != LAST) begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = {line_tag_q, cnt_q + 1'b1, 2'b00};
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stallreq;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int wait_cnt;
    logic hold = 1'b0;
    logic [31:0] exp_addr [$];

    inst_fetch_resp dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .pc        (pc),
        .inst      (inst),
        .stallreq  (stallreq),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory model: ack the request 2 cycles after it appears, data = addr ^ XORV.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst || !mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (hold) begin
                mem_ack = 1'b0;
            end else if (wait_cnt == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ XORV;
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Scoreboard on acked beats, plus the content model on every served fetch.
    always @(negedge clk) begin
        if (rst && mem_req && mem_ack) begin
            if (exp_addr.size() == 0) chk("addr_unexp", mem_addr, 32'hFFFF_FFFF);
            else                      chk("mem_addr", mem_addr, exp_addr.pop_front());
        end
        if (rst && ce && !stallreq) begin
            chk("inst_model", inst, {pc[31:2], 2'b00} ^ XORV);
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            n++;
        end
    endtask

    task automatic wait_fill_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!mem_req) break;
        end
        chk("fill_done", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic wait_beat(input logic [31:0] addr, input logic need_ack);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == addr && (mem_ack || !need_ack)) break;
        end
        chk("beat_seen", mem_addr, addr);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        ce  = 1'b0;
        pc  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst", inst, 32'd0);
        chk("rst_stall", {31'b0, stallreq}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss on line 0.
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        ce = 1'b1; pc = 32'h0;
        @(negedge clk);
        chk("miss_stall", {31'b0, stallreq}, 32'd1);
        chk("miss_noreq", {31'b0, mem_req}, 32'd0);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            n++;
        end
        chk("cold_stall_cycles", n, 32'd4);
        chk("cold_inst", inst, 32'hA5A5_0000);
        wait_fill_done();

        // Sequential hits, no new requests.
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1 pc = 32'(k * 4);
            @(negedge clk);
            chk("seq_stall", {31'b0, stallreq}, 32'd0);
            chk("seq_inst", inst, XORV ^ 32'(k * 4));
            chk("seq_noreq", {31'b0, mem_req}, 32'd0);
        end

        // Jump to another line mid-fill.
        ce = 1'b0;
        do_reset();
        exp_addr.push_back(32'h0);   exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);   exp_addr.push_back(32'hC);
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h108); exp_addr.push_back(32'h10C);
        ce = 1'b1; pc = 32'h0;
        wait_beat(32'h4, 1'b1);
        @(posedge clk);
        #1 pc = 32'h104;
        count_stall(n);
        chk("jump_stall_cycles", n, 32'd13);
        chk("jump_inst", inst, 32'hA5A5_0104);
        wait_fill_done();

        // Fetch disabled.
        @(posedge clk);
        #1 ce = 1'b0; pc = 32'h200;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ce0_inst", inst, 32'd0);
            chk("ce0_stall", {31'b0, stallreq}, 32'd0);
            chk("ce0_req", {31'b0, mem_req}, 32'd0);
        end

        // Asynchronous reset during the beat at 0x8.
        @(posedge clk);
        #1 ce = 1'b1; pc = 32'h0;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        wait_beat(32'h8, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("async_req", {31'b0, mem_req}, 32'd0);
        chk("async_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1; pc = 32'h4;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        @(posedge clk);
        #1;
        count_stall(n);
        chk("rst_refill_cycles", n, 32'd6);
        chk("rst_refill_inst", inst, 32'hA5A5_0004);
        wait_fill_done();

        // Memory stalls indefinitely on the beat at 0x8.
        ce = 1'b0;
        do_reset();
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        ce = 1'b1; pc = 32'h8;
        wait_beat(32'h8, 1'b0);
        hold = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("hold_req", {31'b0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, 32'h8);
            chk("hold_stall", {31'b0, stallreq}, 32'd1);
        end
        hold = 1'b0;
        count_stall(n);
        chk("hold_inst", inst, 32'hA5A5_0008);
        wait_fill_done();

        chk("q_empty", exp_addr.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
